// File: rtl/seven_seg_capture_if.sv
// Bus bundle for the seven-segment capture block: raw Pmod lines in, decoded value and status out.
interface seven_seg_capture_if;
    logic [7:0] seg_in;
    logic [7:0] value;
    logic       valid;
    logic       bad_glyph;
    logic       stale;

    // master drives the Pmod bus and observes the capture results
    modport master (output seg_in, input value, valid, bad_glyph, stale);
    modport slave  (input seg_in, output value, valid, bad_glyph, stale);
endinterface

// File: rtl/seven_seg_capture.sv
// Receive side of a two-digit multiplexed seven-segment bus: sync, debounce, decode, reassemble.
// Define SEVEN_SEG_CAPTURE_HEX_EN to also decode the A-F glyphs.
module seven_seg_capture #(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic CLK,
    input logic RST_N,
    seven_seg_capture_if.slave bus
);
    localparam logic [7:0]  CNT_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0]  CNT_ACC = 8'(STABLE_CYCLES - 1);
    localparam logic [20:0] TO_MAX  = 21'(TIMEOUT_CYCLES);
    localparam logic [20:0] TO_LAST = 21'(TIMEOUT_CYCLES - 1);

    logic [7:0]  s1, s2, prev;
    logic [7:0]  cnt;
    logic [20:0] tcnt;
    logic [3:0]  msb_slot, lsb_slot;
    logic        msb_seen, lsb_seen, assembled;
    logic [7:0]  value_q;
    logic        valid_q, bad_q, stale_q;

    logic        accept, blank, is_lsb, other_seen, timeout_hit;
    logic [6:0]  seg;
    logic [4:0]  dec;
    logic [7:0]  new_value;

    // returns {decodable, nibble}; segments ordered g..a, active-high
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        r = 5'h00;
        case (s)
            7'h3F: r = {1'b1, 4'h0};
            7'h06: r = {1'b1, 4'h1};
            7'h5B: r = {1'b1, 4'h2};
            7'h4F: r = {1'b1, 4'h3};
            7'h66: r = {1'b1, 4'h4};
            7'h6D: r = {1'b1, 4'h5};
            7'h7D: r = {1'b1, 4'h6};
            7'h07: r = {1'b1, 4'h7};
            7'h7F: r = {1'b1, 4'h8};
            7'h6F: r = {1'b1, 4'h9};
`ifdef SEVEN_SEG_CAPTURE_HEX_EN
            7'h77: r = {1'b1, 4'hA};
            7'h7C: r = {1'b1, 4'hB};
            7'h39: r = {1'b1, 4'hC};
            7'h5E: r = {1'b1, 4'hD};
            7'h79: r = {1'b1, 4'hE};
            7'h71: r = {1'b1, 4'hF};
`endif
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    always_comb begin
        accept      = (s2 == prev) && (cnt == CNT_ACC);
        seg         = ~s2[6:0];
        blank       = (seg == 7'h00);
        dec         = decode(seg);
        is_lsb      = s2[7];
        other_seen  = is_lsb ? msb_seen : lsb_seen;
        new_value   = is_lsb ? {msb_slot, dec[3:0]} : {dec[3:0], lsb_slot};
        // an accept in the terminal-count cycle keeps the capture fresh
        timeout_hit = !accept && (tcnt == TO_LAST);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1        <= '0;
            s2        <= '0;
            prev      <= '0;
            cnt       <= '0;
            tcnt      <= '0;
            msb_slot  <= '0;
            lsb_slot  <= '0;
            msb_seen  <= 1'b0;
            lsb_seen  <= 1'b0;
            assembled <= 1'b0;
            value_q   <= '0;
            valid_q   <= 1'b0;
            bad_q     <= 1'b0;
            stale_q   <= 1'b0;
        end else begin
            s1      <= bus.seg_in;
            s2      <= s1;
            prev    <= s2;
            valid_q <= 1'b0;

            if (s2 != prev)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 8'd1;

            if (accept) begin
                tcnt    <= '0;
                stale_q <= 1'b0;
            end else if (tcnt != TO_MAX) begin
                tcnt <= tcnt + 21'd1;
            end

            if (timeout_hit) begin
                stale_q   <= 1'b1;
                msb_seen  <= 1'b0;
                lsb_seen  <= 1'b0;
                assembled <= 1'b0;
            end

            if (accept && !blank) begin
                if (dec[4]) begin
                    bad_q <= 1'b0;
                    if (is_lsb) begin
                        lsb_slot <= dec[3:0];
                        lsb_seen <= 1'b1;
                    end else begin
                        msb_slot <= dec[3:0];
                        msb_seen <= 1'b1;
                    end
                    if (other_seen) begin
                        value_q   <= new_value;
                        assembled <= 1'b1;
                        valid_q   <= (new_value != value_q) || !assembled;
                    end
                end else begin
                    bad_q <= 1'b1;
                end
            end
        end
    end

    assign bus.value     = value_q;
    assign bus.valid     = valid_q;
    assign bus.bad_glyph = bad_q;
    assign bus.stale     = stale_q;
endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture; expected values queued as stimulus is driven, popped on valid.
module tb_seven_seg_capture;
    localparam int S = 16;
    localparam int T = 300;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    int total = 0;
    int bad = 0;
    int nvalid = 0;
    int nv0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;

    seven_seg_capture_if bus();

    seven_seg_capture #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want)
        else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // scoreboard: every valid pulse must match the next queued value
    always @(posedge CLK) begin
        #1;
        if (bus.valid === 1'b1) begin
            nvalid++;
            total++;
            assert (exp_q.size() != 0)
            else begin
                bad++;
                $error("FAIL unexpected_valid got value=%0h want=no pulse", bus.value);
            end
            if (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                check("sb_value", 32'(bus.value), 32'(exp_v));
            end
        end
    end

    initial begin
        bus.seg_in = 8'hFF;
        tick(3);
        check("rst_value", 32'(bus.value), 32'h0);
        check("rst_valid", 32'(bus.valid), 32'h0);
        check("rst_bad", 32'(bus.bad_glyph), 32'h0);
        check("rst_stale", 32'(bus.stale), 32'h0);
        RST_N = 1'b1;
        tick(2);

        // alternate "4" msb / "2" lsb
        exp_q.push_back(8'h42);
        for (int r = 0; r < 3; r++) begin
            bus.seg_in = 8'h19;
            tick(64);
            bus.seg_in = 8'hA4;
            tick(64);
            if (r == 0) check("first_42", 32'(bus.value), 32'h42);
        end
        check("alt_one_valid", 32'(nvalid), 32'd1);
        check("alt_value", 32'(bus.value), 32'h42);

        // lsb changes to "3": exact latency
        exp_q.push_back(8'h43);
        bus.seg_in = 8'hB0;
        tick(S + 2);
        check("lat_early", 32'(bus.valid), 32'h0);
        tick(1);
        check("lat_valid", 32'(bus.valid), 32'h1);
        check("lat_value", 32'(bus.value), 32'h43);
        tick(30);

        // glitching bus: no accepts, eventually stale
        nv0 = nvalid;
        repeat (40) begin
            bus.seg_in = 8'h19;
            tick(5);
            bus.seg_in = 8'h00;
            tick(5);
        end
        check("glitch_no_valid", 32'(nvalid), 32'(nv0));
        check("glitch_value", 32'(bus.value), 32'h43);
        check("glitch_stale", 32'(bus.stale), 32'h1);

        // undecodable glyph, then recovery
        bus.seg_in = 8'hFE;
        tick(S + 3);
        check("bad_set", 32'(bus.bad_glyph), 32'h1);
        check("bad_stale_clr", 32'(bus.stale), 32'h0);
        check("bad_value", 32'(bus.value), 32'h43);
        tick(10);
        bus.seg_in = 8'hA4;
        tick(S + 3);
        check("bad_clr", 32'(bus.bad_glyph), 32'h0);
        check("bad_value2", 32'(bus.value), 32'h43);
        tick(10);

        // hex glyph "A" on msb
`ifdef SEVEN_SEG_CAPTURE_HEX_EN
        exp_q.push_back(8'hA2);
`endif
        bus.seg_in = 8'h08;
        tick(S + 3);
`ifdef SEVEN_SEG_CAPTURE_HEX_EN
        check("hex_value", 32'(bus.value), 32'hA2);
        check("hex_bad", 32'(bus.bad_glyph), 32'h0);
`else
        check("hex_bad", 32'(bus.bad_glyph), 32'h1);
        check("hex_value", 32'(bus.value), 32'h43);
`endif
        tick(10);

        exp_q.push_back(8'h42);
        bus.seg_in = 8'h19;
        tick(S + 3);
        check("recap_value", 32'(bus.value), 32'h42);
        check("recap_bad", 32'(bus.bad_glyph), 32'h0);
        tick(5);

        // blank bus: one accept restarts timeout, stale at exactly T after it
        bus.seg_in = 8'hFF;
        tick(S + 3);
        tick(T - 1);
        check("to_early", 32'(bus.stale), 32'h0);
        tick(1);
        check("to_stale", 32'(bus.stale), 32'h1);
        check("to_value", 32'(bus.value), 32'h42);
        tick(10);
        check("to_hold", 32'(bus.stale), 32'h1);

        // asynchronous reset mid-operation
        #2;
        RST_N = 1'b0;
        #1;
        check("arst_value", 32'(bus.value), 32'h0);
        check("arst_valid", 32'(bus.valid), 32'h0);
        check("arst_bad", 32'(bus.bad_glyph), 32'h0);
        check("arst_stale", 32'(bus.stale), 32'h0);
        tick(3);
        RST_N = 1'b1;
        tick(2);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
`ifdef SEVEN_SEG_CAPTURE_HEX_EN
        check("valid_count", 32'(nvalid), 32'd4);
`else
        check("valid_count", 32'(nvalid), 32'd3);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
